// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid defaults, coordinate types and the food-placer
// state encoding (also used by the game-control FSM).
package snake_pkg;

    localparam int DEF_GRID_W       = 40;
    localparam int DEF_GRID_H       = 30;
    localparam int DEF_MAX_TRIES    = 16;
    localparam int DEF_RAND_TIMEOUT = 8;

    localparam int X_BITS    = 6;
    localparam int Y_BITS    = 5;
    localparam int RAND_BITS = 14;

    typedef logic [X_BITS-1:0] coord_x_t;
    typedef logic [Y_BITS-1:0] coord_y_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_RAND = 3'd2,
        ST_CHECK     = 3'd3,
        ST_WAIT_HIT  = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAIL      = 3'd6
    } food_state_t;

endpackage

// File: rtl/food_coord_map.sv
// Maps a raw LFSR number onto a grid cell and flags off-grid cells.
// With FOOD_SCAN_FALLBACK_EN it also produces the raster-order successor of a cell.
module food_coord_map
    import snake_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic [RAND_BITS-1:0] num,
    output logic                 num_valid,
    output coord_x_t             num_x,
    output coord_y_t             num_y,
    output logic                 num_in_range
`ifdef FOOD_SCAN_FALLBACK_EN
    ,
    input  coord_x_t             cur_x,
    input  coord_y_t             cur_y,
    output coord_x_t             step_x,
    output coord_y_t             step_y
`endif
);

    localparam coord_x_t X_LAST = coord_x_t'(GRID_W - 1);
    localparam coord_y_t Y_LAST = coord_y_t'(GRID_H - 1);

    // Bits above X_BITS+Y_BITS only take part in the "nonzero = valid" test.
    assign num_valid    = (num != {RAND_BITS{1'b0}});
    assign num_x        = num[X_BITS-1:0];
    assign num_y        = num[X_BITS+Y_BITS-1:X_BITS];
    assign num_in_range = (num_x <= X_LAST) && (num_y <= Y_LAST);

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam coord_x_t X_ONE = coord_x_t'(1);
    localparam coord_y_t Y_ONE = coord_y_t'(1);

    // Raster successor: x wraps to 0 and bumps y, y wraps to 0 at the last row.
    always_comb begin
        step_x = cur_x;
        step_y = cur_y;
        if (cur_x >= X_LAST) begin
            step_x = {X_BITS{1'b0}};
            if (cur_y >= Y_LAST) begin
                step_y = {Y_BITS{1'b0}};
            end else begin
                step_y = cur_y + Y_ONE;
            end
        end else begin
            step_x = cur_x + X_ONE;
        end
    end
`endif

endmodule

// File: rtl/snake_food_placer.sv
// Food placer: requests LFSR numbers, rejects off-grid and occupied cells, publishes the food cell.
// Optional FOOD_SCAN_FALLBACK_EN: after MAX_TRIES failed draws, scan the grid for a free cell.
module snake_food_placer
    import snake_pkg::*;
#(
    parameter int GRID_W       = DEF_GRID_W,
    parameter int GRID_H       = DEF_GRID_H,
    parameter int MAX_TRIES    = DEF_MAX_TRIES,
    parameter int RAND_TIMEOUT = DEF_RAND_TIMEOUT
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_FoodReq,
    output logic                 o_Busy,
    output logic                 o_RandNeed,
    input  logic [RAND_BITS-1:0] i_RandNum,
    output coord_x_t             o_QryX,
    output coord_y_t             o_QryY,
    input  logic                 i_QryHit,
    output coord_x_t             o_FoodX,
    output coord_y_t             o_FoodY,
    output logic                 o_FoodValid,
    output logic                 o_Fail
);

    localparam int TRY_BITS = $clog2(MAX_TRIES + 1);
    localparam int TMO_BITS = $clog2(RAND_TIMEOUT + 1);
    localparam logic [TRY_BITS-1:0] TRY_LAST = TRY_BITS'(MAX_TRIES);
    localparam logic [TRY_BITS-1:0] TRY_ONE  = TRY_BITS'(1);
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(RAND_TIMEOUT - 1);
    localparam logic [TMO_BITS-1:0] TMO_ONE  = TMO_BITS'(1);

    food_state_t         state_r, state_nxt_s;
    logic [TRY_BITS-1:0] try_r, try_nxt_s;
    logic [TMO_BITS-1:0] tmo_r, tmo_nxt_s;
    coord_x_t            qry_x_r, qry_x_nxt_s, food_x_r;
    coord_y_t            qry_y_r, qry_y_nxt_s, food_y_r;
    logic                retry_s;
    logic                busy_r, rand_need_r, food_valid_r, fail_r;
    logic                busy_nxt_s, rand_need_nxt_s, food_valid_nxt_s, fail_nxt_s;
    logic                num_valid_s, num_in_range_s;
    coord_x_t            num_x_s;
    coord_y_t            num_y_s;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic                scan_r, scan_nxt_s;
    logic                have_cand_r, have_cand_nxt_s;
    coord_x_t            start_x_r, start_x_nxt_s, step_x_s;
    coord_y_t            start_y_r, start_y_nxt_s, step_y_s;
`endif

    food_coord_map #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_coord_map (
        .num          (i_RandNum),
        .num_valid    (num_valid_s),
        .num_x        (num_x_s),
        .num_y        (num_y_s),
        .num_in_range (num_in_range_s)
`ifdef FOOD_SCAN_FALLBACK_EN
        ,
        .cur_x        (qry_x_r),
        .cur_y        (qry_y_r),
        .step_x       (step_x_s),
        .step_y       (step_y_s)
`endif
    );

    // State, counters, query address and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r      <= ST_IDLE;
            try_r        <= {TRY_BITS{1'b0}};
            tmo_r        <= {TMO_BITS{1'b0}};
            qry_x_r      <= {X_BITS{1'b0}};
            qry_y_r      <= {Y_BITS{1'b0}};
            food_x_r     <= {X_BITS{1'b0}};
            food_y_r     <= {Y_BITS{1'b0}};
            busy_r       <= 1'b0;
            rand_need_r  <= 1'b0;
            food_valid_r <= 1'b0;
            fail_r       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_r       <= 1'b0;
            have_cand_r  <= 1'b0;
            start_x_r    <= {X_BITS{1'b0}};
            start_y_r    <= {Y_BITS{1'b0}};
`endif
        end else begin
            state_r      <= state_nxt_s;
            try_r        <= try_nxt_s;
            tmo_r        <= tmo_nxt_s;
            qry_x_r      <= qry_x_nxt_s;
            qry_y_r      <= qry_y_nxt_s;
            busy_r       <= busy_nxt_s;
            rand_need_r  <= rand_need_nxt_s;
            food_valid_r <= food_valid_nxt_s;
            fail_r       <= fail_nxt_s;
            if (state_nxt_s == ST_DONE) begin
                food_x_r <= qry_x_r;
                food_y_r <= qry_y_r;
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_r       <= scan_nxt_s;
            have_cand_r  <= have_cand_nxt_s;
            start_x_r    <= start_x_nxt_s;
            start_y_r    <= start_y_nxt_s;
`endif
        end
    end

    // Next state plus try/timeout counters and query address.
    always_comb begin
        state_nxt_s     = state_r;
        try_nxt_s       = try_r;
        tmo_nxt_s       = tmo_r;
        qry_x_nxt_s     = qry_x_r;
        qry_y_nxt_s     = qry_y_r;
        retry_s         = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_nxt_s      = scan_r;
        have_cand_nxt_s = have_cand_r;
        start_x_nxt_s   = start_x_r;
        start_y_nxt_s   = start_y_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_FoodReq) begin
                    state_nxt_s     = ST_REQ;
                    try_nxt_s       = {TRY_BITS{1'b0}};
`ifdef FOOD_SCAN_FALLBACK_EN
                    scan_nxt_s      = 1'b0;
                    have_cand_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                tmo_nxt_s   = {TMO_BITS{1'b0}};
                state_nxt_s = ST_WAIT_RAND;
            end
            ST_WAIT_RAND: begin
                if (num_valid_s) begin
                    try_nxt_s = try_r + TRY_ONE;
                    if (num_in_range_s) begin
                        qry_x_nxt_s     = num_x_s;
                        qry_y_nxt_s     = num_y_s;
                        state_nxt_s     = ST_CHECK;
`ifdef FOOD_SCAN_FALLBACK_EN
                        have_cand_nxt_s = 1'b1;
`endif
                    end else begin
                        retry_s = 1'b1;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    try_nxt_s = try_r + TRY_ONE;
                    retry_s   = 1'b1;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_ONE;
                end
            end
            ST_CHECK: begin
                state_nxt_s = ST_WAIT_HIT;
            end
            ST_WAIT_HIT: begin
                if (!i_QryHit) begin
                    state_nxt_s = ST_DONE;
`ifdef FOOD_SCAN_FALLBACK_EN
                end else if (scan_r) begin
                    if ((step_x_s == start_x_r) && (step_y_s == start_y_r)) begin
                        state_nxt_s = ST_FAIL;
                    end else begin
                        qry_x_nxt_s = step_x_s;
                        qry_y_nxt_s = step_y_s;
                        state_nxt_s = ST_CHECK;
                    end
`endif
                end else begin
                    retry_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_FAIL: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A rejected draw either asks again or, when the tries are spent, gives up.
        if (retry_s) begin
            if (try_nxt_s == TRY_LAST) begin
`ifdef FOOD_SCAN_FALLBACK_EN
                scan_nxt_s  = 1'b1;
                state_nxt_s = ST_CHECK;
                if (have_cand_r) begin
                    start_x_nxt_s = qry_x_r;
                    start_y_nxt_s = qry_y_r;
                end else begin
                    qry_x_nxt_s   = {X_BITS{1'b0}};
                    qry_y_nxt_s   = {Y_BITS{1'b0}};
                    start_x_nxt_s = {X_BITS{1'b0}};
                    start_y_nxt_s = {Y_BITS{1'b0}};
                end
`else
                state_nxt_s = ST_FAIL;
`endif
            end else begin
                state_nxt_s = ST_REQ;
            end
        end else begin
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        busy_nxt_s       = 1'b0;
        rand_need_nxt_s  = 1'b0;
        food_valid_nxt_s = 1'b0;
        fail_nxt_s       = 1'b0;
        case (state_nxt_s)
            ST_REQ: begin
                busy_nxt_s      = 1'b1;
                rand_need_nxt_s = 1'b1;
            end
            ST_WAIT_RAND, ST_CHECK, ST_WAIT_HIT: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                food_valid_nxt_s = 1'b1;
            end
            ST_FAIL: begin
                fail_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign o_Busy      = busy_r;
    assign o_RandNeed  = rand_need_r;
    assign o_QryX      = qry_x_r;
    assign o_QryY      = qry_y_r;
    assign o_FoodX     = food_x_r;
    assign o_FoodY     = food_y_r;
    assign o_FoodValid = food_valid_r;
    assign o_Fail      = fail_r;

endmodule

// File: tb/tb_snake_food_placer.sv
// Bench for snake_food_placer: LFSR and occupancy responders, result scoreboard,
// table of placement scenarios plus hand sequences for busy-ignore and mid-run reset.
module tb_snake_food_placer;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_FoodReq;
    logic        o_Busy;
    logic        o_RandNeed;
    logic [13:0] i_RandNum;
    logic [5:0]  o_QryX;
    logic [4:0]  o_QryY;
    logic        i_QryHit;
    logic [5:0]  o_FoodX;
    logic [4:0]  o_FoodY;
    logic        o_FoodValid;
    logic        o_Fail;

    snake_food_placer dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_FoodReq   (i_FoodReq),
        .o_Busy      (o_Busy),
        .o_RandNeed  (o_RandNeed),
        .i_RandNum   (i_RandNum),
        .o_QryX      (o_QryX),
        .o_QryY      (o_QryY),
        .i_QryHit    (i_QryHit),
        .o_FoodX     (o_FoodX),
        .o_FoodY     (o_FoodY),
        .o_FoodValid (o_FoodValid),
        .o_Fail      (o_Fail)
    );

    typedef struct {
        logic [13:0] d0;
        int          n0;
        logic [13:0] d1;
        int          n1;
        int          occ;
        int          needs;
        int          gap;
        bit          fail;
        int          fx;
        int          fy;
        int          lat;
    } vec_t;

    typedef struct {
        bit fail;
        int fx;
        int fy;
        int lat;
        int req_cyc;
    } exp_t;

    vec_t        vecs [5];
    exp_t        exp_q [$];
    logic [13:0] draw_q [$];
    int          pulse_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          bad_qry = 0;
    int          occ_mode = 0;

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        forever begin
            @(posedge i_Clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit occupied(input int x, input int y);
        case (occ_mode)
            1:       return (x == 5) && (y == 4);
            2:       return !((x == 3) && (y == 0));
            default: return 1'b0;
        endcase
    endfunction

    // LFSR model: answer each o_RandNeed three cycles later with the next queued draw.
    initial begin
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        i_RandNum = 14'h0000;
        forever begin
            @(negedge i_Clk);
            i_RandNum = 14'h0000;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (draw_q.size() > 0) i_RandNum = draw_q.pop_front();
                end
            end
            if (o_RandNeed) begin
                pulse_q.push_back(cyc);
                pend = 1'b1;
                cnt = 3;
            end
        end
    end

    // Occupancy model: hit reflects the address shown one cycle earlier.
    initial begin
        int px;
        int py;
        px = 0;
        py = 0;
        i_QryHit = 1'b0;
        forever begin
            @(negedge i_Clk);
            i_QryHit = occupied(px, py);
            px = int'(o_QryX);
            py = int'(o_QryY);
        end
    end

    // Result monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clk);
            if (int'(o_QryX) > 39 || int'(o_QryY) > 29) bad_qry++;
            if (o_FoodValid || o_Fail) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_result: valid=%0b fail=%0b, expected no result (cycle %0d)",
                             o_FoodValid, o_Fail, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_fail", int'(o_Fail), int'(e.fail));
                    chk("food_x", int'(o_FoodX), e.fx);
                    chk("food_y", int'(o_FoodY), e.fy);
                    chk("latency", cyc - e.req_cyc, e.lat);
                    chk("busy_at_result", int'(o_Busy), 0);
                end
            end
        end
    end

    task automatic wait_results();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge i_Clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge i_Clk);
    endtask

    initial begin
        int   rc;
        int   gap_bad;
        exp_t e;
        vec_t v;

        vecs[0] = '{14'h0105, 1, 14'h0000, 0, 0, 1, 0, 1'b0, 5, 4, 7};
        vecs[1] = '{14'h003F, 1, 14'h0105, 1, 0, 2, 4, 1'b0, 5, 4, 11};
        vecs[2] = '{14'h0105, 1, 14'h0042, 1, 1, 2, 6, 1'b0, 2, 1, 13};
`ifdef FOOD_SCAN_FALLBACK_EN
        vecs[3] = '{14'h003F, 16, 14'h0000, 0, 2, 16, 4, 1'b0, 3, 0, 73};
        vecs[4] = '{14'h0000, 0, 14'h0000, 0, 2, 16, 9, 1'b0, 3, 0, 153};
`else
        vecs[3] = '{14'h003F, 16, 14'h0000, 0, 2, 16, 4, 1'b1, 2, 1, 65};
        vecs[4] = '{14'h0000, 0, 14'h0000, 0, 2, 16, 9, 1'b1, 2, 1, 145};
`endif

        i_Rst = 1'b1;
        i_FoodReq = 1'b0;
        repeat (3) @(negedge i_Clk);
        chk("reset_outputs", int'({o_Busy, o_RandNeed, o_FoodValid, o_Fail,
                                   o_QryX, o_QryY, o_FoodX, o_FoodY}), 0);
        i_Rst = 1'b0;
        repeat (2) @(negedge i_Clk);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            draw_q.delete();
            pulse_q.delete();
            for (int j = 0; j < v.n0; j++) draw_q.push_back(v.d0);
            for (int j = 0; j < v.n1; j++) draw_q.push_back(v.d1);
            occ_mode = v.occ;
            @(negedge i_Clk);
            rc = cyc;
            i_FoodReq = 1'b1;
            e = '{v.fail, v.fx, v.fy, v.lat, rc};
            exp_q.push_back(e);
            @(negedge i_Clk);
            i_FoodReq = 1'b0;
            wait_results();
            chk("rand_pulses", pulse_q.size(), v.needs);
            chk("rand_first", (pulse_q.size() > 0) ? pulse_q[0] - rc : -1, 1);
            gap_bad = 0;
            for (int j = 1; j < pulse_q.size(); j++)
                if (pulse_q[j] - pulse_q[j-1] != v.gap) gap_bad++;
            chk("rand_gap", gap_bad, 0);
        end

        // Second request while busy must be dropped.
        draw_q.delete();
        pulse_q.delete();
        draw_q.push_back(14'h0105);
        occ_mode = 0;
        @(negedge i_Clk);
        rc = cyc;
        i_FoodReq = 1'b1;
        e = '{1'b0, 5, 4, 7, rc};
        exp_q.push_back(e);
        @(negedge i_Clk);
        i_FoodReq = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk("busy_mid", int'(o_Busy), 1);
        i_FoodReq = 1'b1;
        @(negedge i_Clk);
        i_FoodReq = 1'b0;
        wait_results();
        repeat (12) @(negedge i_Clk);
        chk("busy_ignore_pulses", pulse_q.size(), 1);

        // Reset while waiting for the hit aborts silently.
        draw_q.delete();
        pulse_q.delete();
        draw_q.push_back(14'h0105);
        @(negedge i_Clk);
        i_FoodReq = 1'b1;
        @(negedge i_Clk);
        i_FoodReq = 1'b0;
        repeat (5) @(negedge i_Clk);
        chk("pre_rst_qry_x", int'(o_QryX), 5);
        chk("pre_rst_busy", int'(o_Busy), 1);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        chk("rst_outputs", int'({o_Busy, o_RandNeed, o_FoodValid, o_Fail,
                                 o_QryX, o_QryY, o_FoodX, o_FoodY}), 0);
        i_Rst = 1'b0;
        repeat (15) @(negedge i_Clk);
        chk("rst_pulses", pulse_q.size(), 1);
        chk("offgrid_queries", bad_qry, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
